// File: rtl/tb_segment_ctrl.sv
// -----------------------------------------------------------------------------
// tb_segment_ctrl
//
// Traceback segment scheduler for one frame at a time over a circular
// survivor memory. It counts survivor words written by the ACS and launches
// traceback segments:
//   - non-final (sliding window): reads 2*W_HALF steps and releases W_HALF bits
//   - final: releases every remaining undecoded step of the frame
// The ACS is held off whenever another write could overwrite steps that have
// not been decoded yet.
//
// Handshake (ACS side): a survivor word is accepted only in a cycle where
// acs_step_valid_i=1 and acs_stall_o=0. acs_stall_o depends only on registered
// state, never on acs_step_valid_i. A write offered while stalled is dropped.
// Traceback side: tb_segment_start_o is a one-cycle pulse, at most one segment
// is outstanding, and tb_bits_valid_i closes it. tb_bits_valid_i with no
// outstanding segment is ignored.
//
// Ports
//   clk_i, rst_an_i, rst_sync_i    clock, async active-low reset, sync clear
//   frame_start_i/frame_len_i/zero_tail_i   frame setup (accepted in IDLE only)
//   acs_step_valid_i, acs_stall_o, best_state_i   ACS write side
//   tb_segment_start_o, tb_start_addr_o, tb_len_o,
//   tb_decoding_end_o, tb_start_state_o           segment command
//   tb_busy_i, tb_bits_valid_i                    traceback status
//   out_valid_o, out_count_o, out_last_o          decoded-bit release
//   busy_o, frame_done_o                          frame status
//   dbg_state_o                                   current FSM state
// -----------------------------------------------------------------------------
module tb_segment_ctrl #(
    parameter int W_TB_LEN = 7,
    parameter int W_HALF   = 32,
    parameter int W_FULL   = 64,
    parameter int W_FRM    = 16
) (
    input  logic                clk_i,
    input  logic                rst_an_i,
    input  logic                rst_sync_i,
    input  logic                frame_start_i,
    input  logic [W_FRM-1:0]    frame_len_i,
    input  logic                zero_tail_i,
    input  logic                acs_step_valid_i,
    output logic                acs_stall_o,
    input  logic [5:0]          best_state_i,
    output logic                tb_segment_start_o,
    output logic [W_TB_LEN-1:0] tb_start_addr_o,
    output logic [W_TB_LEN:0]   tb_len_o,
    output logic                tb_decoding_end_o,
    output logic [5:0]          tb_start_state_o,
    input  logic                tb_busy_i,
    input  logic                tb_bits_valid_i,
    output logic                out_valid_o,
    output logic [W_TB_LEN:0]   out_count_o,
    output logic                out_last_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RUN_NF = 3'd2,
        S_RUN_F  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [W_TB_LEN:0] NF_LEN    = (W_TB_LEN+1)'(2 * W_HALF);
    localparam logic [W_TB_LEN:0] HALF_LEN  = (W_TB_LEN+1)'(W_HALF);
    localparam logic [W_TB_LEN:0] FULL_LEN  = (W_TB_LEN+1)'(W_FULL);
    localparam logic [W_TB_LEN:0] STALL_LVL = (W_TB_LEN+1)'(W_FULL + W_HALF);

    state_t state_q, state_d;

    logic [W_TB_LEN-1:0] wp_q;
    logic [W_FRM-1:0]    written_q;
    logic [W_FRM-1:0]    frame_len_q;
    logic                zero_tail_q;
    logic [W_TB_LEN:0]   pending_q;
    logic [W_TB_LEN:0]   pending_d;

    logic all_written;
    logic accept;
    logic frame_go;
    logic frame_zero;
    logic issue_nf;
    logic issue_f;
    logic nf_done;
    logic f_done;

    // Once every step of the frame is in the survivor memory no more writes
    // are allowed; the remaining work is pure traceback.
    assign all_written = (written_q == frame_len_q);

    assign acs_stall_o = (state_q == S_IDLE) || (state_q == S_DONE) ||
                         all_written || (pending_q >= STALL_LVL);

    assign accept      = acs_step_valid_i && !acs_stall_o;
    assign busy_o      = (state_q == S_WAIT) || (state_q == S_RUN_NF) ||
                         (state_q == S_RUN_F);
    assign dbg_state_o = state_q;

    // ---------------------------------------------------------------------
    // Next-state and control strobes
    // ---------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        frame_go   = 1'b0;
        frame_zero = 1'b0;
        issue_nf   = 1'b0;
        issue_f    = 1'b0;
        nf_done    = 1'b0;
        f_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    if (frame_len_i != '0) begin
                        frame_go = 1'b1;
                        state_d  = S_WAIT;
                    end else begin
                        // Empty frame: report completion, never touch traceback.
                        frame_zero = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!tb_busy_i) begin
                    if (!all_written && (pending_q >= NF_LEN)) begin
                        issue_nf = 1'b1;
                        state_d  = S_RUN_NF;
                    end else if (all_written && (pending_q > FULL_LEN)) begin
                        // Tail too long for one final pass: keep sliding.
                        issue_nf = 1'b1;
                        state_d  = S_RUN_NF;
                    end else if (all_written) begin
                        issue_f = 1'b1;
                        state_d = S_RUN_F;
                    end
                end
            end
            S_RUN_NF: begin
                if (tb_bits_valid_i) begin
                    nf_done = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_RUN_F: begin
                if (tb_bits_valid_i) begin
                    f_done  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write and release can land in the same cycle; both are applied.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = pending_d + (W_TB_LEN+1)'(1);
        end
        if (nf_done) begin
            pending_d = pending_d - HALF_LEN;
        end
        if (f_done) begin
            pending_d = '0;
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= S_IDLE;
        end else if (rst_sync_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Counters and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            wp_q               <= '0;
            written_q          <= '0;
            pending_q          <= '0;
            frame_len_q        <= '0;
            zero_tail_q        <= 1'b0;
            tb_segment_start_o <= 1'b0;
            tb_start_addr_o    <= '0;
            tb_len_o           <= '0;
            tb_decoding_end_o  <= 1'b0;
            tb_start_state_o   <= '0;
            out_valid_o        <= 1'b0;
            out_count_o        <= '0;
            out_last_o         <= 1'b0;
            frame_done_o       <= 1'b0;
        end else if (rst_sync_i) begin
            wp_q               <= '0;
            written_q          <= '0;
            pending_q          <= '0;
            frame_len_q        <= '0;
            zero_tail_q        <= 1'b0;
            tb_segment_start_o <= 1'b0;
            tb_start_addr_o    <= '0;
            tb_len_o           <= '0;
            tb_decoding_end_o  <= 1'b0;
            tb_start_state_o   <= '0;
            out_valid_o        <= 1'b0;
            out_count_o        <= '0;
            out_last_o         <= 1'b0;
            frame_done_o       <= 1'b0;
        end else begin
            if (frame_go) begin
                frame_len_q <= frame_len_i;
                zero_tail_q <= zero_tail_i;
                wp_q        <= '0;
                written_q   <= '0;
                pending_q   <= '0;
            end else begin
                if (accept) begin
                    wp_q      <= wp_q + W_TB_LEN'(1);
                    written_q <= written_q + W_FRM'(1);
                end
                pending_q <= pending_d;
            end

            tb_segment_start_o <= issue_nf || issue_f;
            if (issue_nf || issue_f) begin
                // wp points at the next free slot; the newest word is one back.
                tb_start_addr_o   <= wp_q - W_TB_LEN'(1);
                tb_len_o          <= issue_f ? pending_q : NF_LEN;
                tb_decoding_end_o <= issue_f;
                tb_start_state_o  <= (issue_f && zero_tail_q) ? 6'd0 : best_state_i;
            end

            out_valid_o <= nf_done || f_done;
            out_last_o  <= f_done;
            if (nf_done) begin
                out_count_o <= HALF_LEN;
            end else if (f_done) begin
                out_count_o <= tb_len_o;
            end

            frame_done_o <= frame_zero || (state_q == S_DONE);
        end
    end

endmodule

// File: tb/tb_tb_segment_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for tb_segment_ctrl. A per-cycle reference model tracks the frame in
// terms of steps written, undecoded steps and the outstanding segment, and
// predicts each segment command, each bit release and each frame_done pulse
// together with the cycle it must appear in. Scenario tasks compare the
// predicted and captured event lists plus scenario-specific constants.
// -----------------------------------------------------------------------------
module tb_tb_segment_ctrl;
  localparam int W_TB_LEN = 7;
  localparam int W_HALF   = 32;
  localparam int W_FULL   = 64;
  localparam int W_FRM    = 16;
  localparam int DEPTH    = 1 << W_TB_LEN;

  // clock / reset block
  logic clk_i = 1'b0;
  logic rst_an_i = 1'b0;
  logic rst_sync_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               frame_start_i = 1'b0;
  logic [W_FRM-1:0]   frame_len_i = '0;
  logic               zero_tail_i = 1'b0;
  logic               acs_step_valid_i = 1'b0;
  logic [5:0]         best_state_i = '0;
  logic               tb_busy_i = 1'b0;
  logic               tb_bits_valid_i = 1'b0;
  logic               acs_stall_o;
  logic               tb_segment_start_o;
  logic [W_TB_LEN-1:0] tb_start_addr_o;
  logic [W_TB_LEN:0]  tb_len_o;
  logic               tb_decoding_end_o;
  logic [5:0]         tb_start_state_o;
  logic               out_valid_o;
  logic [W_TB_LEN:0]  out_count_o;
  logic               out_last_o;
  logic               busy_o;
  logic               frame_done_o;
  logic [2:0]         dbg_state_o;

  tb_segment_ctrl #(.W_TB_LEN(W_TB_LEN), .W_HALF(W_HALF), .W_FULL(W_FULL), .W_FRM(W_FRM)) dut (
    .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i),
    .frame_start_i(frame_start_i), .frame_len_i(frame_len_i), .zero_tail_i(zero_tail_i),
    .acs_step_valid_i(acs_step_valid_i), .acs_stall_o(acs_stall_o), .best_state_i(best_state_i),
    .tb_segment_start_o(tb_segment_start_o), .tb_start_addr_o(tb_start_addr_o),
    .tb_len_o(tb_len_o), .tb_decoding_end_o(tb_decoding_end_o),
    .tb_start_state_o(tb_start_state_o), .tb_busy_i(tb_busy_i),
    .tb_bits_valid_i(tb_bits_valid_i), .out_valid_o(out_valid_o),
    .out_count_o(out_count_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .dbg_state_o(dbg_state_o)
  );

  // scoreboard: segment words {cyc16, addr7, len8, end1, state6}
  logic [37:0] exp_q[$];
  logic [37:0] got_seg_q[$];
  // release words {cyc16, count8, last1}
  logic [24:0] exp_out_q[$];
  logic [24:0] got_out_q[$];
  logic [15:0] exp_fd_q[$];
  logic [15:0] got_fd_q[$];
  int stall_mis, busy_mis;
  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int cyc = 0;
  int m_active = 0, m_in_done = 0, m_len = 0, m_zt = 0;
  int m_written = 0, m_pending = 0, m_out = 0, m_flen = 0;
  int run_done, start_cyc;

  task automatic sb_clear();
    exp_q.delete(); got_seg_q.delete();
    exp_out_q.delete(); got_out_q.delete();
    exp_fd_q.delete(); got_fd_q.delete();
    stall_mis = 0; busy_mis = 0;
  endtask

  // driver: one clock with the currently applied inputs, model advanced alongside
  task automatic step();
    bit m_stall, acc, iss, fin, cmp, fs_go, fs_zero;
    logic [W_TB_LEN-1:0] a;
    logic [W_TB_LEN:0] l;
    logic [5:0] ss;
    m_stall = (m_active == 0) || (m_written == m_len) || (m_pending >= W_FULL + W_HALF);
    if (acs_stall_o !== m_stall) stall_mis++;
    acc = acs_step_valid_i && !m_stall;
    iss = (m_active != 0) && (m_out == 0) && !tb_busy_i &&
          ((m_written < m_len && m_pending >= 2 * W_HALF) || m_written == m_len);
    fin = iss && (m_written == m_len) && (m_pending <= W_FULL);
    cmp = tb_bits_valid_i && (m_out != 0);
    fs_go   = frame_start_i && (m_active == 0) && (m_in_done == 0) && (frame_len_i != 0);
    fs_zero = frame_start_i && (m_active == 0) && (m_in_done == 0) && (frame_len_i == 0);
    a = '0; l = '0; ss = '0;
    if (!rst_sync_i) begin
      if (iss) begin
        a  = W_TB_LEN'((m_written + DEPTH - 1) % DEPTH);
        l  = fin ? (W_TB_LEN+1)'(m_pending) : (W_TB_LEN+1)'(2 * W_HALF);
        ss = (fin && m_zt != 0) ? 6'd0 : best_state_i;
        exp_q.push_back({16'(cyc + 1), a, l, fin, ss});
      end
      if (cmp) exp_out_q.push_back({16'(cyc + 1), (m_out == 2) ? 8'(m_flen) : 8'(W_HALF), m_out == 2});
      if (m_in_done != 0 || fs_zero) exp_fd_q.push_back(16'(cyc + 1));
    end
    @(posedge clk_i); #1;
    cyc++;
    if (tb_segment_start_o) got_seg_q.push_back({16'(cyc), tb_start_addr_o, tb_len_o, tb_decoding_end_o, tb_start_state_o});
    if (out_valid_o) got_out_q.push_back({16'(cyc), 8'(out_count_o), out_last_o});
    if (frame_done_o) got_fd_q.push_back(16'(cyc));
    if (rst_sync_i) begin
      m_active = 0; m_in_done = 0; m_out = 0; m_written = 0; m_pending = 0;
    end else begin
      m_in_done = 0;
      if (cmp) begin
        if (m_out == 2) begin m_active = 0; m_in_done = 1; m_pending = 0; end
        else m_pending -= W_HALF;
        m_out = 0;
      end
      if (m_active != 0) begin m_pending += int'(acc); m_written += int'(acc); end
      if (iss) begin m_out = fin ? 2 : 1; if (fin) m_flen = int'(l); end
      if (fs_go) begin
        m_active = 1; m_len = int'(frame_len_i); m_zt = int'(zero_tail_i);
        m_written = 0; m_pending = 0; m_out = 0;
      end
    end
    if (busy_o !== (m_active != 0)) busy_mis++;
  endtask

  // driver: start a frame, stream ACS writes and emulate the traceback unit
  // (lat < 0: traceback never completes; inj >= 0: stray frame_start at that cycle)
  task automatic run_frame(input int len, input bit zt, input int lat, input int pct,
                           input int budget, input int inj);
    int since;
    bit outst;
    start_cyc = cyc;
    frame_len_i = W_FRM'(len); zero_tail_i = zt; frame_start_i = 1'b1;
    acs_step_valid_i = 1'b0; tb_bits_valid_i = 1'b0; tb_busy_i = 1'b0;
    best_state_i = 6'($urandom_range(0, 63));
    step();
    frame_start_i = 1'b0;
    run_done = frame_done_o ? 1 : 0;
    outst = 1'b0; since = 0;
    for (int c = 0; c < budget && run_done == 0; c++) begin
      frame_start_i = (c == inj);
      frame_len_i = (c == inj) ? W_FRM'(7) : frame_len_i;
      acs_step_valid_i = ($urandom_range(1, 100) <= pct);
      best_state_i = 6'($urandom_range(0, 63));
      tb_bits_valid_i = outst && (lat >= 0) && (since == lat);
      tb_busy_i = outst;
      step();
      if (tb_bits_valid_i) outst = 1'b0;
      if (tb_segment_start_o) begin outst = 1'b1; since = 0; end
      else since++;
      if (frame_done_o) run_done = 1;
    end
    frame_start_i = 1'b0; acs_step_valid_i = 1'b0;
    tb_bits_valid_i = 1'b0; tb_busy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_an_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++; if (tb_segment_start_o !== 1'b0) begin n_err++; $display("FAIL reset_seg_start got %0b want 0", tb_segment_start_o); end
    n_vec++; if ({tb_start_addr_o, tb_len_o, tb_decoding_end_o, tb_start_state_o} !== '0) begin n_err++; $display("FAIL reset_seg_fields got %h want 0", {tb_start_addr_o, tb_len_o, tb_decoding_end_o, tb_start_state_o}); end
    n_vec++; if ({out_valid_o, out_count_o, out_last_o} !== '0) begin n_err++; $display("FAIL reset_out got %h want 0", {out_valid_o, out_count_o, out_last_o}); end
    n_vec++; if ({busy_o, frame_done_o} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got %b want 00", {busy_o, frame_done_o}); end
    n_vec++; if (dbg_state_o !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state_o); end
    rst_an_i = 1'b1;
    sb_clear();
    acs_step_valid_i = 1'b1;
    repeat (4) step();
    acs_step_valid_i = 1'b0;
    n_vec++; if (stall_mis !== 0) begin n_err++; $display("FAIL idle_stall mismatching cycles %0d want 0", stall_mis); end
  endtask

  task automatic test_single_final();
    sb_clear();
    run_frame(40, 1'b1, 3, 100, 200, -1);
    n_vec++; if (run_done !== 1) begin n_err++; $display("FAIL single_done got %0d want 1", run_done); end
    n_vec++; if (got_seg_q.size() !== 1) begin n_err++; $display("FAIL single_nseg got %0d want 1", got_seg_q.size()); end
    else begin
      n_vec++; if (got_seg_q[0][21:0] !== {7'd39, 8'd40, 1'b1, 6'd0}) begin n_err++; $display("FAIL single_fields got %h want %h", got_seg_q[0][21:0], {7'd39, 8'd40, 1'b1, 6'd0}); end
    end
    foreach (exp_q[i]) begin
      n_vec++; if (i >= got_seg_q.size() || got_seg_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_seg[%0d] got %h want %h", i, (i < got_seg_q.size()) ? got_seg_q[i] : 'x, exp_q[i]); end
    end
    n_vec++; if (got_out_q.size() !== 1) begin n_err++; $display("FAIL single_nout got %0d want 1", got_out_q.size()); end
    else begin
      n_vec++; if (got_out_q[0][8:0] !== {8'd40, 1'b1}) begin n_err++; $display("FAIL single_out got %h want %h", got_out_q[0][8:0], {8'd40, 1'b1}); end
      n_vec++; if (got_fd_q.size() !== 1 || got_fd_q[0] !== got_out_q[0][24:9] + 16'd1) begin n_err++; $display("FAIL single_fd_timing got %0d pulses want 1 one cycle after release", got_fd_q.size()); end
    end
    n_vec++; if (stall_mis + busy_mis !== 0) begin n_err++; $display("FAIL single_stall_busy got %0d/%0d want 0/0", stall_mis, busy_mis); end
  endtask

  task automatic test_sliding();
    int s;
    sb_clear();
    run_frame(100, 1'b0, 3, 100, 400, -1);
    n_vec++; if (run_done !== 1) begin n_err++; $display("FAIL slide_done got %0d want 1", run_done); end
    n_vec++; if (got_seg_q.size() < 2 || got_seg_q[0][21:6] !== {7'd63, 8'd64, 1'b0}) begin n_err++; $display("FAIL slide_first got %h want %h", (got_seg_q.size() > 0) ? got_seg_q[0][21:6] : 'x, {7'd63, 8'd64, 1'b0}); end
    n_vec++; if (got_seg_q.size() !== exp_q.size()) begin n_err++; $display("FAIL slide_nseg got %0d want %0d", got_seg_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; if (i >= got_seg_q.size() || got_seg_q[i] !== exp_q[i]) begin n_err++; $display("FAIL slide_seg[%0d] got %h want %h", i, (i < got_seg_q.size()) ? got_seg_q[i] : 'x, exp_q[i]); end
    end
    foreach (exp_out_q[i]) begin
      n_vec++; if (i >= got_out_q.size() || got_out_q[i] !== exp_out_q[i]) begin n_err++; $display("FAIL slide_out[%0d] got %h want %h", i, (i < got_out_q.size()) ? got_out_q[i] : 'x, exp_out_q[i]); end
    end
    s = 0;
    foreach (got_out_q[i]) s += int'(got_out_q[i][8:1]);
    n_vec++; if (s !== 100) begin n_err++; $display("FAIL slide_sum got %0d want 100", s); end
    n_vec++; if (got_seg_q.size() == 0 || got_seg_q[got_seg_q.size()-1][6] !== 1'b1 || got_seg_q[got_seg_q.size()-1][14:7] > 8'd64) begin n_err++; $display("FAIL slide_final_len got %h want end=1 len<=64", (got_seg_q.size() > 0) ? got_seg_q[got_seg_q.size()-1][21:0] : 'x); end
    n_vec++; if (got_fd_q.size() !== exp_fd_q.size() || (got_fd_q.size() > 0 && got_fd_q[0] !== exp_fd_q[0])) begin n_err++; $display("FAIL slide_fd got %0d pulses want %0d", got_fd_q.size(), exp_fd_q.size()); end
    n_vec++; if (stall_mis + busy_mis !== 0) begin n_err++; $display("FAIL slide_stall_busy got %0d/%0d want 0/0", stall_mis, busy_mis); end
  endtask

  task automatic test_stall();
    sb_clear();
    run_frame(200, 1'b0, -1, 100, 140, -1);
    n_vec++; if (acs_stall_o !== 1'b1) begin n_err++; $display("FAIL stall_high got %0b want 1", acs_stall_o); end
    n_vec++; if (stall_mis !== 0) begin n_err++; $display("FAIL stall_profile mismatching cycles %0d want 0", stall_mis); end
    // offered writes while stalled must not move the write pointer
    acs_step_valid_i = 1'b1; tb_busy_i = 1'b1; tb_bits_valid_i = 1'b1;
    step();
    tb_bits_valid_i = 1'b0; tb_busy_i = 1'b0; acs_step_valid_i = 1'b0;
    repeat (3) step();
    n_vec++; if (got_seg_q.size() !== 2 || got_seg_q[1][21:6] !== {7'd95, 8'd64, 1'b0}) begin n_err++; $display("FAIL stall_wp_hold got %0d segs, last %h want 2 segs, %h", got_seg_q.size(), (got_seg_q.size() > 0) ? got_seg_q[got_seg_q.size()-1][21:6] : 'x, {7'd95, 8'd64, 1'b0}); end
    foreach (exp_q[i]) begin
      n_vec++; if (i >= got_seg_q.size() || got_seg_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_seg[%0d] got %h want %h", i, (i < got_seg_q.size()) ? got_seg_q[i] : 'x, exp_q[i]); end
    end
    rst_sync_i = 1'b1; step(); rst_sync_i = 1'b0;
  endtask

  task automatic test_wrap();
    int s;
    sb_clear();
    run_frame(300, 1'b0, int'($urandom_range(0, 5)), 70, 3000, -1);
    n_vec++; if (run_done !== 1) begin n_err++; $display("FAIL wrap_done got %0d want 1", run_done); end
    n_vec++; if (got_seg_q.size() == 0 || got_seg_q[got_seg_q.size()-1][21:15] !== 7'd43) begin n_err++; $display("FAIL wrap_final_addr got %h want 43", (got_seg_q.size() > 0) ? got_seg_q[got_seg_q.size()-1][21:15] : 'x); end
    foreach (got_seg_q[i]) begin
      n_vec++; if (got_seg_q[i][14:7] > 8'd64) begin n_err++; $display("FAIL wrap_len[%0d] got %0d want <=64", i, got_seg_q[i][14:7]); end
    end
    n_vec++; if (got_seg_q.size() !== exp_q.size()) begin n_err++; $display("FAIL wrap_nseg got %0d want %0d", got_seg_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; if (i >= got_seg_q.size() || got_seg_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_seg[%0d] got %h want %h", i, (i < got_seg_q.size()) ? got_seg_q[i] : 'x, exp_q[i]); end
    end
    s = 0;
    foreach (got_out_q[i]) s += int'(got_out_q[i][8:1]);
    n_vec++; if (s !== 300) begin n_err++; $display("FAIL wrap_sum got %0d want 300", s); end
    n_vec++; if (stall_mis + busy_mis !== 0) begin n_err++; $display("FAIL wrap_stall_busy got %0d/%0d want 0/0", stall_mis, busy_mis); end
  endtask

  task automatic test_frame_edges();
    sb_clear();
    run_frame(0, 1'b0, 2, 100, 20, -1);
    n_vec++; if (got_fd_q.size() !== 1 || got_fd_q[0] !== 16'(start_cyc + 1)) begin n_err++; $display("FAIL empty_fd got %0d pulses (first at %0d) want 1 at %0d", got_fd_q.size(), (got_fd_q.size() > 0) ? got_fd_q[0] : 16'hffff, start_cyc + 1); end
    n_vec++; if (got_seg_q.size() !== 0 || got_out_q.size() !== 0) begin n_err++; $display("FAIL empty_noseg got %0d segs %0d releases want 0 0", got_seg_q.size(), got_out_q.size()); end
    sb_clear();
    run_frame(40, 1'b1, 1, 100, 200, 5);
    n_vec++; if (run_done !== 1 || got_seg_q.size() !== 1 || got_seg_q[0][14:6] !== {8'd40, 1'b1}) begin n_err++; $display("FAIL busy_restart got done=%0d segs=%0d want done=1, one final seg of 40", run_done, got_seg_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; if (i >= got_seg_q.size() || got_seg_q[i] !== exp_q[i]) begin n_err++; $display("FAIL edge_seg[%0d] got %h want %h", i, (i < got_seg_q.size()) ? got_seg_q[i] : 'x, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    sb_clear();
    run_frame(100, 1'b1, -1, 100, 70, -1);
    n_vec++; if (busy_o !== 1'b1 || got_seg_q.size() !== 1) begin n_err++; $display("FAIL mid_setup got busy=%0b segs=%0d want 1 1", busy_o, got_seg_q.size()); end
    rst_sync_i = 1'b1; tb_bits_valid_i = 1'b1;
    step();
    rst_sync_i = 1'b0; tb_bits_valid_i = 1'b0;
    n_vec++; if ({tb_segment_start_o, tb_start_addr_o, tb_len_o, tb_decoding_end_o, tb_start_state_o, out_valid_o, out_count_o, out_last_o, busy_o, frame_done_o} !== '0) begin n_err++; $display("FAIL mid_outputs got %h want 0", {tb_segment_start_o, tb_start_addr_o, tb_len_o, tb_decoding_end_o, tb_start_state_o, out_valid_o, out_count_o, out_last_o, busy_o, frame_done_o}); end
    n_vec++; if (dbg_state_o !== 3'd0) begin n_err++; $display("FAIL mid_state got %0d want 0", dbg_state_o); end
    sb_clear();
    run_frame(40, 1'b1, 3, 100, 200, -1);
    n_vec++; if (run_done !== 1 || got_seg_q.size() !== 1 || got_seg_q[0][21:0] !== {7'd39, 8'd40, 1'b1, 6'd0}) begin n_err++; $display("FAIL mid_rerun got done=%0d segs=%0d want one seg %h", run_done, got_seg_q.size(), {7'd39, 8'd40, 1'b1, 6'd0}); end
    n_vec++; if (got_out_q.size() !== 1 || got_out_q[0][8:0] !== {8'd40, 1'b1}) begin n_err++; $display("FAIL mid_rerun_out got %0d releases want 1 of 40/last", got_out_q.size()); end
  endtask

  task automatic test_back_to_back();
    int len, s;
    for (int f = 0; f < 4; f++) begin
      sb_clear();
      len = int'($urandom_range(1, 400));
      run_frame(len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                int'($urandom_range(40, 100)), 4000, -1);
      n_vec++; if (run_done !== 1) begin n_err++; $display("FAIL b2b%0d_done len %0d got %0d want 1", f, len, run_done); end
      n_vec++; if (got_seg_q.size() !== exp_q.size() || got_out_q.size() !== exp_out_q.size()) begin n_err++; $display("FAIL b2b%0d_counts got %0d/%0d want %0d/%0d", f, got_seg_q.size(), got_out_q.size(), exp_q.size(), exp_out_q.size()); end
      foreach (exp_q[i]) begin
        n_vec++; if (i >= got_seg_q.size() || got_seg_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b%0d_seg[%0d] got %h want %h", f, i, (i < got_seg_q.size()) ? got_seg_q[i] : 'x, exp_q[i]); end
      end
      foreach (exp_out_q[i]) begin
        n_vec++; if (i >= got_out_q.size() || got_out_q[i] !== exp_out_q[i]) begin n_err++; $display("FAIL b2b%0d_out[%0d] got %h want %h", f, i, (i < got_out_q.size()) ? got_out_q[i] : 'x, exp_out_q[i]); end
      end
      s = 0;
      foreach (got_out_q[i]) s += int'(got_out_q[i][8:1]);
      n_vec++; if (s !== len) begin n_err++; $display("FAIL b2b%0d_sum got %0d want %0d", f, s, len); end
      n_vec++; if (stall_mis + busy_mis !== 0) begin n_err++; $display("FAIL b2b%0d_stall_busy got %0d/%0d want 0/0", f, stall_mis, busy_mis); end
    end
  endtask

  initial begin
    test_reset();
    test_single_final();
    test_sliding();
    test_stall();
    test_wrap();
    test_frame_edges();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end
endmodule
